// File: rtl/d_mem_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package d_mem_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_MEM_SIZE_WORDS = 256;
    localparam int DEF_LOCK_MAX       = 64;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        lock;
    } mem_req_t;

    // Keep only the bytes selected by be; unselected lanes read as zero.
    function automatic logic [31:0] be_mask(input logic [31:0] data, input logic [3:0] be);
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end else begin
                res[8*b +: 8] = 8'h00;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/d_mem_arb_if.sv
// Requester-side bus of the data-memory arbiter: requests in, grants and responses out.
interface d_mem_arb_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       rq_req;
    logic [NUM_REQ-1:0]       rq_wr;
    logic [NUM_REQ-1:0][31:0] rq_addr;
    logic [NUM_REQ-1:0][31:0] rq_wdata;
    logic [NUM_REQ-1:0][3:0]  rq_be;
    logic [NUM_REQ-1:0]       rq_lock;
    logic [NUM_REQ-1:0]       rq_gnt;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [31:0]              rsp_rdata;
    logic                     rsp_err;
    logic                     lock_err;

    modport master (
        output rq_req, rq_wr, rq_addr, rq_wdata, rq_be, rq_lock,
        input  rq_gnt, rsp_valid, rsp_rdata, rsp_err, lock_err
    );

    modport slave (
        input  rq_req, rq_wr, rq_addr, rq_wdata, rq_be, rq_lock,
        output rq_gnt, rsp_valid, rsp_rdata, rsp_err, lock_err
    );
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first masked requester after the pointer, one-hot.
module rr_arb #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  gnt_o
);
    logic [N-1:0]  req_m_s;
    logic          found_s;
    logic [PW-1:0] idx_s;

    // Cyclic scan starting one past the pointer; the pointer itself has lowest priority.
    always_comb begin
        req_m_s = req_i & mask_i;
        gnt_o   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = PW'((int'(ptr_i) + k) % N);
            if (!found_s && req_m_s[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/d_mem_arb.sv
// Data-memory arbiter: round-robin with lock, range check and registered responses.
module d_mem_arb
    import d_mem_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int MEM_SIZE_WORDS = DEF_MEM_SIZE_WORDS,
    parameter int LOCK_MAX       = DEF_LOCK_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    d_mem_arb_if.slave         bus,
    output logic [31:0]        mem_addr,
    output logic               mem_wr_en,
    output logic [31:0]        mem_wr_data,
    output logic [3:0]         mem_byte_en,
    input  logic [31:0]        mem_rd_data
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LOCK_MAX) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

    arb_state_e          state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                lock_err_q, lock_err_d;

    mem_req_t            req_s [NUM_REQ];
    mem_req_t            sel_s;
    logic [NUM_REQ-1:0]  mask_s;
    logic [NUM_REQ-1:0]  pick_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [PW-1:0]       gidx_s;
    logic                acc_s;
    logic                in_range_s;

    // Gather the per-requester bus fields into request records.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_s[i] = '{wr: bus.rq_wr[i], addr: bus.rq_addr[i], wdata: bus.rq_wdata[i],
                         be: bus.rq_be[i], lock: bus.rq_lock[i]};
        end
    end

    // While locked only the owner is eligible; otherwise everyone is.
    always_comb begin
        mask_s = '0;
        case (state_q)
            ARB_IDLE:   mask_s = '1;
            ARB_LOCKED: mask_s[owner_q] = 1'b1;
            default:    mask_s = '1;
        endcase
    end

    rr_arb #(.N(NUM_REQ), .PW(PW)) u_rr_arb (
        .req_i  (bus.rq_req),
        .ptr_i  (ptr_q),
        .mask_i (mask_s),
        .gnt_o  (pick_s)
    );

    // Grant is suppressed while reset is held; decode the winner's index and request.
    always_comb begin
        gnt_s  = rst_n ? pick_s : '0;
        acc_s  = |gnt_s;
        gidx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                gidx_s = PW'(i);
            end else begin
                gidx_s = gidx_s;
            end
        end
        sel_s      = req_s[gidx_s];
        in_range_s = (sel_s.addr < 32'(MEM_SIZE_WORDS));
    end

    // Drive the memory from the granted requester; out-of-range accesses never write.
    always_comb begin
        mem_addr    = 32'h0000_0000;
        mem_wr_en   = 1'b0;
        mem_wr_data = 32'h0000_0000;
        mem_byte_en = 4'h0;
        if (acc_s) begin
            mem_addr    = sel_s.addr;
            mem_wr_data = sel_s.wdata;
            mem_wr_en   = sel_s.wr & in_range_s;
            mem_byte_en = in_range_s ? sel_s.be : 4'h0;
        end else begin
            mem_addr = 32'h0000_0000;
        end
    end

    // Next response: strobe for the winner, masked read data, range error flag.
    always_comb begin
        rsp_valid_d = gnt_s;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = acc_s & ~in_range_s;
        if (acc_s && !sel_s.wr && in_range_s) begin
            rsp_rdata_d = be_mask(mem_rd_data, sel_s.be);
        end else begin
            rsp_rdata_d = 32'h0000_0000;
        end
    end

    // Arbitration FSM: pointer follows each winner, lock holds ownership with a timeout.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ptr_d      = acc_s ? gidx_s : ptr_q;
        lock_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (acc_s && sel_s.lock) begin
                    state_d = ARB_LOCKED;
                    owner_d = gidx_s;
                    cnt_d   = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (acc_s && !sel_s.lock) begin
                    state_d = ARB_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    // Owner held on too long: serve this access, then force release.
                    state_d    = ARB_IDLE;
                    lock_err_d = 1'b1;
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            ptr_q       <= PW'(NUM_REQ - 1);
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign bus.rq_gnt    = gnt_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.lock_err  = lock_err_q;

endmodule

// File: tb/tb_d_mem_arb.sv
// Randomized bench for d_mem_arb with a behavioural reference model and directed checks.
module tb_d_mem_arb;
    localparam int N    = 2;
    localparam int MSZ  = 256;
    localparam int LMAX = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rd_data;

    d_mem_arb_if #(.NUM_REQ(N)) bus ();

    d_mem_arb #(.NUM_REQ(N), .MEM_SIZE_WORDS(MSZ), .LOCK_MAX(LMAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_byte_en (mem_byte_en),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory array (environment), addressed by the low address bits.
    logic [31:0] tb_mem [MSZ];
    assign mem_rd_data = (mem_addr < 32'(MSZ)) ? tb_mem[mem_addr[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) tb_mem[mem_addr[7:0]][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [MSZ];
    bit          m_locked;
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    logic [N-1:0] e_valid;
    logic [31:0]  e_rdata;
    logic         e_err;
    logic         e_lerr;

    // Samples taken during the last cycle() for directed literal checks
    logic [N-1:0] s_gnt;
    logic         s_wr_en;
    logic         s_lerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_ptr    = N - 1;
        e_valid  = '0;
        e_rdata  = 32'h0;
        e_err    = 1'b0;
        e_lerr   = 1'b0;
    endtask

    function automatic int model_grant();
        if (m_locked) return bus.rq_req[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (bus.rq_req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic clr();
        bus.rq_req = '0; bus.rq_wr = '0; bus.rq_lock = '0;
        for (int i = 0; i < N; i++) begin
            bus.rq_addr[i] = 32'h0; bus.rq_wdata[i] = 32'h0; bus.rq_be[i] = 4'h0;
        end
    endtask

    task automatic drive(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input bit lk);
        bus.rq_req[i] = 1'b1; bus.rq_wr[i] = wr; bus.rq_addr[i] = a;
        bus.rq_wdata[i] = wd; bus.rq_be[i] = be; bus.rq_lock[i] = lk;
    endtask

    // One clock cycle: compare everything against the model, then advance the model.
    task automatic cycle();
        int g;
        logic [N-1:0] eg;
        logic [31:0] a;
        bit inr;
        logic [N-1:0] n_valid;
        logic [31:0] n_rdata;
        logic n_err, n_lerr, n_locked;
        int n_owner, n_cnt, n_ptr;
        #1;
        g  = model_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        a   = (g >= 0) ? bus.rq_addr[g] : 32'h0;
        inr = (a < 32'(MSZ));
        chk("gnt", 32'(bus.rq_gnt), 32'(eg));
        chk("mem_addr", mem_addr, a);
        chk("mem_wr_en", 32'(mem_wr_en), (g >= 0) ? 32'(bus.rq_wr[g] & inr) : 32'h0);
        chk("mem_wr_data", mem_wr_data, (g >= 0) ? bus.rq_wdata[g] : 32'h0);
        chk("mem_byte_en", 32'(mem_byte_en), (g >= 0 && inr) ? 32'(bus.rq_be[g]) : 32'h0);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        chk("lock_err", 32'(bus.lock_err), 32'(e_lerr));
        s_gnt = bus.rq_gnt; s_wr_en = mem_wr_en; s_lerr = bus.lock_err;

        n_valid = eg; n_rdata = 32'h0; n_err = 1'b0; n_lerr = 1'b0;
        n_locked = m_locked; n_owner = m_owner; n_cnt = m_cnt; n_ptr = m_ptr;
        if (g >= 0) begin
            n_ptr = g;
            if (!inr) n_err = 1'b1;
            else if (bus.rq_wr[g]) begin
                for (int b = 0; b < 4; b++)
                    if (bus.rq_be[g][b]) ref_mem[a[7:0]][8*b +: 8] = bus.rq_wdata[g][8*b +: 8];
            end else n_rdata = bmask(ref_mem[a[7:0]], bus.rq_be[g]);
        end
        if (!m_locked) begin
            if (g >= 0 && bus.rq_lock[g]) begin
                n_locked = 1'b1; n_owner = g; n_cnt = 0;
            end
        end else begin
            if (g >= 0 && !bus.rq_lock[g]) n_locked = 1'b0;
            else if (m_cnt == LMAX - 1) begin n_locked = 1'b0; n_lerr = 1'b1; end
            else n_cnt = m_cnt + 1;
        end
        @(posedge clk);
        e_valid = n_valid; e_rdata = n_rdata; e_err = n_err; e_lerr = n_lerr;
        m_locked = n_locked; m_owner = n_owner; m_cnt = n_cnt; m_ptr = n_ptr;
        @(negedge clk);
    endtask

    logic [N-1:0] seq [4];

    initial begin
        rst_n = 1'b0;
        clr();
        for (int i = 0; i < MSZ; i++) begin
            tb_mem[i] = $urandom; ref_mem[i] = tb_mem[i];
        end
        tb_mem[0] = 32'h0BADF00D; ref_mem[0] = 32'h0BADF00D;
        tb_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        tb_mem[9] = 32'hAABBCCDD; ref_mem[9] = 32'hAABBCCDD;
        model_reset();
        @(negedge clk);
        bus.rq_req = '1;
        #1;
        chk("gnt_in_reset", 32'(bus.rq_gnt), 32'h0);
        chk("mem_wr_en_in_reset", 32'(mem_wr_en), 32'h0);
        chk("rsp_valid_reset", 32'(bus.rsp_valid), 32'h0);
        chk("lock_err_reset", 32'(bus.lock_err), 32'h0);
        clr();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention from reset: grants alternate starting at requester 0
        for (int c = 0; c < 4; c++) begin
            clr();
            drive(0, 1'b0, 32'd1, 32'h0, 4'hF, 1'b0);
            drive(1, 1'b0, 32'd2, 32'h0, 4'hF, 1'b0);
            cycle();
            seq[c] = s_gnt;
        end
        chk("cont_g0", 32'(seq[0]), 32'h1);
        chk("cont_g1", 32'(seq[1]), 32'h2);
        chk("cont_g2", 32'(seq[2]), 32'h1);
        chk("cont_g3", 32'(seq[3]), 32'h2);
        chk("cont_last_rsp", 32'(bus.rsp_valid), 32'h2);

        // Single read of address 5
        clr();
        drive(0, 1'b0, 32'd5, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("rd_gnt", 32'(s_gnt), 32'h1);
        chk("rd_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rd_data", bus.rsp_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(bus.rsp_err), 32'h0);

        // Byte write then read back
        clr();
        drive(1, 1'b1, 32'd9, 32'h11223344, 4'b0101, 1'b0);
        cycle();
        chk("bw_ack_data", bus.rsp_rdata, 32'h0);
        clr();
        drive(1, 1'b0, 32'd9, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("bw_readback", bus.rsp_rdata, 32'hAA22CC44);

        // Lock held by requester 0 against a continuously requesting requester 1
        clr();
        drive(0, 1'b0, 32'd3, 32'h0, 4'hF, 1'b1);
        drive(1, 1'b0, 32'd4, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("lk_first", 32'(s_gnt), 32'h1);
        for (int c = 0; c < 2; c++) begin
            bus.rq_req[0] = 1'b0;
            cycle();
            chk("lk_blocked", 32'(s_gnt), 32'h0);
        end
        drive(0, 1'b0, 32'd3, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("lk_release", 32'(s_gnt), 32'h1);
        bus.rq_req[0] = 1'b0;
        cycle();
        chk("lk_after", 32'(s_gnt), 32'h2);

        // Lock timeout with LOCK_MAX=4
        clr();
        drive(0, 1'b0, 32'd6, 32'h0, 4'hF, 1'b1);
        drive(1, 1'b0, 32'd7, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("to_lock", 32'(s_gnt), 32'h1);
        bus.rq_req[0] = 1'b0;
        for (int c = 0; c < LMAX; c++) begin
            cycle();
            chk("to_blocked", 32'(s_gnt), 32'h0);
            chk("to_no_err", 32'(s_lerr), 32'h0);
        end
        cycle();
        chk("to_gnt1", 32'(s_gnt), 32'h2);
        chk("to_lerr", 32'(s_lerr), 32'h1);
        chk("to_lerr_once", 32'(bus.lock_err), 32'h0);

        // Out-of-range write, then confirm the aliased word is untouched
        clr();
        drive(0, 1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, 1'b0);
        cycle();
        chk("oor_wr_en", 32'(s_wr_en), 32'h0);
        chk("oor_err", 32'(bus.rsp_err), 32'h1);
        chk("oor_rdata", bus.rsp_rdata, 32'h0);
        clr();
        drive(0, 1'b0, 32'd0, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("oor_mem_kept", bus.rsp_rdata, 32'h0BADF00D);

        // Reset with a response pending, then requester 0 wins first
        clr();
        drive(1, 1'b0, 32'd5, 32'h0, 4'hF, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_drop_rdata", bus.rsp_rdata, 32'h0);
        model_reset();
        clr();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 32'd8, 32'h0, 4'hF, 1'b0);
        drive(1, 1'b0, 32'd8, 32'h0, 4'hF, 1'b0);
        cycle();
        chk("rst_first_gnt", 32'(s_gnt), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            clr();
            for (int i = 0; i < N; i++) begin
                int sel;
                logic [31:0] ad;
                sel = $urandom_range(0, 9);
                if (sel == 0) ad = $urandom | 32'h0000_0100;
                else if (sel == 1) ad = 32'(MSZ) + 32'($urandom_range(0, 3));
                else ad = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0)
                    drive(i, 1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 4) == 0));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/d_mem_arb.md
Name: d_mem_arb

Overview:
Shares the single-port data memory between NUM_REQ requesters, e.g. core load/store unit (req 0) and debug/DMA port (req 1).
- Round-robin arbitration with an optional lock, so one requester can keep ownership across read-modify-write sequences.
- Per-requester registered response with range checking.
- Sits directly in front of the data memory array and drives its addr/wr_en/wr_data/byte_en; samples its combinational rd_data.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
MEM_SIZE_WORDS, 256, word count of the attached memory; addresses >= this are out of range
LOCK_MAX, 64, max consecutive cycles a lock may be held before forced release

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rq_req  in  NUM_REQ  access request per requester
rq_wr  in  NUM_REQ  1 = write, 0 = read
rq_addr  in  NUM_REQ x 32  word address
rq_wdata  in  NUM_REQ x 32  write data
rq_be  in  NUM_REQ x 4  byte enables
rq_lock  in  NUM_REQ  hold ownership after this access
rq_gnt  out  NUM_REQ  grant; access accepted when req & gnt
rsp_valid  out  NUM_REQ  one-cycle response strobe
rsp_rdata  out  32  read data, valid with rsp_valid
rsp_err  out  1  out-of-range access, valid with rsp_valid
lock_err  out  1  one-cycle pulse on forced lock release
mem_addr  out  32  to memory
mem_wr_en  out  1  to memory
mem_wr_data  out  32  to memory
mem_byte_en  out  4  to memory
mem_rd_data  in  32  from memory

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_rdata=0, rsp_err=0, lock_err=0; FSM=IDLE; rr pointer=NUM_REQ-1, so req 0 wins first; lock counter=0. rq_gnt and mem_* are combinational and stay 0 while reset is asserted. An in-flight response is dropped.
- Grants and ports:
  - At most one grant per cycle; rq_gnt is combinational from rq_req and state, same cycle.
  - mem_* is driven combinationally from the granted requester. With no grant, mem_addr=0, mem_wr_en=0, mem_byte_en=0, mem_wr_data=0.
- Write latency: data is committed at the clock edge ending the grant cycle.
- Read latency: mem_rd_data is sampled at that same edge.
- Response:
  - rsp_valid[i]=1 for exactly the cycle after an accepted access by i.
  - Reads: rsp_rdata = sampled data.
  - Writes: rsp_rdata=0 (ack only).
  - rsp_rdata and rsp_err are 0 whenever no rsp_valid bit is set.
- Range check: if rq_addr >= MEM_SIZE_WORDS, the access is still granted but mem_wr_en=0 and mem_byte_en=0. The response carries rsp_err=1, rsp_rdata=0.
- Byte enables pass through unchanged; be=0 is legal (no-op write, zero read).
- FSM IDLE:
  - Grant the first requesting index after the rr pointer, scanning cyclically.
  - On acceptance the pointer moves to the granted index.
  - If the accepted access has rq_lock=1, go to LOCKED with owner=i and counter=0.
- FSM LOCKED:
  - Only the owner can be granted; others see gnt=0.
  - Each cycle the counter increments, saturating.
  - An accepted owner access with rq_lock=0 returns the FSM to IDLE after that access.
  - If the counter reaches LOCK_MAX-1 without release, force IDLE next cycle and pulse lock_err; the owner's access in that cycle is still served.
  - An owner with req=0 keeps the lock, and the counter runs.
- Simultaneous requests in IDLE are resolved by rr alone; lock bits of losers are ignored.
- Back-to-back accesses by the same requester: a new access each cycle is allowed, one response per cycle, in order.

Decomposition:
- Package d_mem_pkg:
  - arb state enum {ARB_IDLE, ARB_LOCKED}
  - default NUM_REQ, MEM_SIZE_WORDS, LOCK_MAX constants
  - request struct {wr, addr, wdata, be, lock}
- Sub-module rr_arb: a combinational round-robin picker taking req vector, pointer and mask, returning a one-hot grant. All flops use the existing DFF macros with async reset.

Test Plan:
- Single read: req0 reads addr 5 holding 0xDEADBEEF, be=4'hF -> gnt0 same cycle; next cycle rsp_valid=2'b01, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention: req0 and req1 both request every cycle for 4 cycles -> grants 0,1,0,1; responses follow one cycle later in the same order.
- Byte-write then read: req1 writes 0x11223344 with be=4'b0101 to a word holding 0xAABBCCDD, then reads it -> rsp_rdata=0xAA22CC44.
- Lock: req0 read with lock=1, req1 requesting continuously -> gnt1=0 until req0 issues a lock=0 access, then req1 granted the following cycle.
- Lock timeout, LOCK_MAX=4: req0 locks and then idles -> lock_err pulses once, FSM IDLE, req1 granted next cycle.
- Out of range and reset: write to addr 256 -> mem_wr_en=0, rsp_err=1, memory unchanged. Then assert rst_n=0 with a response pending -> rsp_valid=0 immediately; req0 wins first after reset.
